// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op encodings match the instruction decoder's field layout.
package mult_div_unit_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_RUN  = 2'd1,
      MDU_FIX  = 2'd2
   } mdu_state_e;

   function automatic logic op_is_signed(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic op_is_mult(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bus between decode/register-file side (master) and the multiply/divide unit (slave).
// Signal names follow the datapath's existing net names.
interface mult_div_unit_if #(parameter int WIDTH = 32);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic             MoveToHi;
   logic             MoveToLo;
   logic [WIDTH-1:0] MoveData;
   logic             Busy;
   logic             Done;
   logic             DivByZero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Op, OperandA, OperandB, MoveToHi, MoveToLo, MoveData,
      input  Busy, Done, DivByZero, Hi, Lo
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, MoveToHi, MoveToLo, MoveData,
      output Busy, Done, DivByZero, Hi, Lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// Operates on magnitudes; sign correction is applied once in FIX.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// MDU_IDLE | accepts Start and MTHI/MTLO; Busy low
// MDU_RUN  | one mult/div iteration per edge, count 0..WIDTH-1
// MDU_FIX  | sign-correct, commit Hi/Lo, raise Done next cycle
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic               Clock,
   input  logic               reset,
   mult_div_unit_if.slave     bus
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e         state_q, state_d;
   mdu_op_e            op_q, op_d;
   logic [CW-1:0]      count_q, count_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               neg_q, neg_d;
   logic               sign_a_q, sign_a_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               div_zero_q, div_zero_d;

   mdu_op_e            op_in;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh, diff;
   logic               q_bit;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

   always_comb begin
      op_in = mdu_op_e'(bus.Op);
      a_neg = op_is_signed(op_in) && bus.OperandA[WIDTH-1];
      b_neg = op_is_signed(op_in) && bus.OperandB[WIDTH-1];
      mag_a = a_neg ? -bus.OperandA : bus.OperandA;
      mag_b = b_neg ? -bus.OperandB : bus.OperandB;

      // Multiply: multiplier sits in acc low half and shifts out LSB-first.
      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {add_sum, acc_q[WIDTH-1:1]};

      // Divide: {remainder, dividend/quotient} shifts left, quotient bits enter at LSB.
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      diff     = rem_sh - {1'b0, opnd_q};
      q_bit    = ~diff[WIDTH];
      div_next = {(q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};

      prod_fix = neg_q ? -acc_q : acc_q;
      quot_raw = acc_q[WIDTH-1:0];
      rem_raw  = acc_q[2*WIDTH-1:WIDTH];
      quot_fix = neg_q ? -quot_raw : quot_raw;
      // With a zero divisor the remainder path ends holding |A|, so this restores A.
      rem_fix  = sign_a_q ? -rem_raw : rem_raw;
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      count_d    = count_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      neg_d      = neg_q;
      sign_a_d   = sign_a_q;
      zero_d     = zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      case (state_q)
         MDU_IDLE: begin
            if (bus.MoveToHi) hi_d = bus.MoveData;
            if (bus.MoveToLo) lo_d = bus.MoveData;
            if (bus.Start) begin
               state_d  = MDU_RUN;
               op_d     = op_in;
               count_d  = '0;
               neg_d    = a_neg ^ b_neg;
               sign_a_d = a_neg;
               zero_d   = (bus.OperandB == '0);
               if (op_is_mult(op_in)) begin
                  opnd_d = mag_a;
                  acc_d  = {{WIDTH{1'b0}}, mag_b};
               end else begin
                  opnd_d = mag_b;
                  acc_d  = {{WIDTH{1'b0}}, mag_a};
               end
            end
         end
         MDU_RUN: begin
            acc_d   = op_is_mult(op_q) ? mul_next : div_next;
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) state_d = MDU_FIX;
         end
         MDU_FIX: begin
            state_d = MDU_IDLE;
            done_d  = 1'b1;
            if (op_is_mult(op_q)) begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end else if (zero_q) begin
               hi_d       = rem_fix;
               lo_d       = '1;
               div_zero_d = 1'b1;
            end else begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q    <= MDU_IDLE;
         op_q       <= MDU_MULT;
         count_q    <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         neg_q      <= 1'b0;
         sign_a_q   <= 1'b0;
         zero_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         neg_q      <= neg_d;
         sign_a_q   <= sign_a_d;
         zero_q     <= zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign bus.Busy      = (state_q != MDU_IDLE);
   assign bus.Done      = done_q;
   assign bus.DivByZero = div_zero_q;
   assign bus.Hi        = hi_q;
   assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: results, latency, Busy/Done timing,
// divide-by-zero, MTHI/MTLO gating and mid-operation reset.
module tb_mult_div_unit;

   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .Clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input logic exp_dbz);
      logic [31:0] hi0, lo0;
      int n, busy_n;
      @(negedge clk);
      bus.Op = op; bus.OperandA = a; bus.OperandB = b; bus.Start = 1'b1;
      hi0 = bus.Hi; lo0 = bus.Lo;
      @(negedge clk);
      bus.Start = 1'b0;
      n = 0; busy_n = 0;
      while (!bus.Done && n < 100) begin
         if (bus.Busy) busy_n++;
         if (n == WIDTH / 2) begin
            chk({tag, "_hold_hi"}, bus.Hi, hi0);
            chk({tag, "_hold_lo"}, bus.Lo, lo0);
         end
         n++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, n, WIDTH + 1);
      chk({tag, "_busy_cycles"}, busy_n, WIDTH + 1);
      chk({tag, "_busy_at_done"}, bus.Busy, 1'b0);
      chk({tag, "_hi"}, bus.Hi, exp_hi);
      chk({tag, "_lo"}, bus.Lo, exp_lo);
      chk({tag, "_dbz"}, bus.DivByZero, exp_dbz);
      @(negedge clk);
      chk({tag, "_done_pulse"}, bus.Done, 1'b0);
      chk({tag, "_dbz_pulse"}, bus.DivByZero, 1'b0);
   endtask

   initial begin
      int n;
      logic saw_done;
      bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0;
      bus.MoveToHi = 1'b0; bus.MoveToLo = 1'b0; bus.MoveData = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", bus.Busy, 1'b0);
      chk("rst_done", bus.Done, 1'b0);
      chk("rst_dbz", bus.DivByZero, 1'b0);
      chk("rst_hi", bus.Hi, 32'h0);
      chk("rst_lo", bus.Lo, 32'h0);

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_op("mult_m7x3", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run_op("mult_m5xm4", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFC, 32'h0, 32'd20, 1'b0);
      run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("divu_by0", 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
      run_op("div_m5by0", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

      // Reset ten cycles into a MULT; Lo is non-zero from the previous op.
      @(negedge clk);
      bus.Op = 2'b00; bus.OperandA = 32'hFFFF_FFF9; bus.OperandB = 32'd3; bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", bus.Busy, 1'b0);
      chk("midrst_hi", bus.Hi, 32'h0);
      chk("midrst_lo", bus.Lo, 32'h0);
      saw_done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.Done) saw_done = 1'b1;
         @(negedge clk);
      end
      chk("midrst_no_done", saw_done, 1'b0);

      // MTHI together with Start, then MTHI and Start while busy.
      @(negedge clk);
      bus.Op = 2'b01; bus.OperandA = 32'd3; bus.OperandB = 32'd5; bus.Start = 1'b1;
      bus.MoveToHi = 1'b1; bus.MoveData = 32'h77;
      @(negedge clk);
      bus.Start = 1'b0; bus.MoveToHi = 1'b0;
      chk("mv_start_hi", bus.Hi, 32'h77);
      chk("mv_start_busy", bus.Busy, 1'b1);
      repeat (3) @(negedge clk);
      bus.MoveToHi = 1'b1; bus.MoveData = 32'hAAAA;
      bus.Op = 2'b11; bus.OperandA = 32'd9; bus.OperandB = 32'd9; bus.Start = 1'b1;
      repeat (2) @(negedge clk);
      bus.MoveToHi = 1'b0; bus.Start = 1'b0;
      chk("mthi_busy_ignored", bus.Hi, 32'h77);
      n = 0;
      while (!bus.Done && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("busy_op_done_seen", bus.Done, 1'b1);
      chk("busy_op_hi", bus.Hi, 32'h0);
      chk("busy_op_lo", bus.Lo, 32'd15);
      @(negedge clk);
      chk("no_requeue_busy", bus.Busy, 1'b0);
      chk("no_requeue_done", bus.Done, 1'b0);

      bus.MoveToLo = 1'b1; bus.MoveData = 32'h55;
      @(negedge clk);
      bus.MoveToLo = 1'b0;
      chk("mtlo_lo", bus.Lo, 32'h55);
      chk("mtlo_hi_kept", bus.Hi, 32'h0);
      chk("mtlo_busy", bus.Busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
